// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH steps; optional subtract via SERIAL_ADD_SUB_EN.
// Latency: done/sum valid WIDTH cycles after the accepting start edge; one op per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is only honoured in IDLE or DONE and dropped (not queued) while busy.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  // New sum bit enters at the MSB so after WIDTH steps bit 0 lands at bit 0.
  assign res_nxt = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= res_nxt;
            cout  <= fa_c;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised scoreboard bench for serial_adder_ctrl: expected results and completion cycles
// are queued at issue time and checked by an independent done monitor.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [WIDTH:0] res;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: done=1 at cycle %0d with nothing outstanding (sum=%0h cout=%0b)",
                 cyc, sum, cout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({cout, sum} !== e.res || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result: got cout/sum=%0h at cycle %0d, expected %0h at cycle %0d",
                   {cout, sum}, cyc, e.res, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic ci, input logic s);
    logic sub_on;
`ifdef SERIAL_ADD_SUB_EN
    sub_on = s;
`else
    sub_on = 1'b0;
`endif
    if (sub_on) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
  endfunction

  // Call just after a rising edge with the DUT in IDLE or DONE; returns just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci, input logic s);
    exp_t e;
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    step();
    start = 1'b0;
    e.res = model(x, y, ci, s);
    e.cyc = cyc + WIDTH;
    exp_q.push_back(e);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Full op; optional ignored start pulse on RUN cycle inj. Returns in the DONE cycle.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                       input logic s, input int inj);
    issue(x, y, ci, s);
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) chk("busy_run", 32'(busy), 32'd1);
      if (i == inj) begin
        start = 1'b1;
        a = 8'hAA;
        b = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      step();
      start = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    #10 rst_n = 1'b1;
    step();

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, -1);
    step();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    step();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
    step();
    do_op(8'h03, 8'h04, 1'b0, 1'b0, 3);
    repeat (3) step();
    wait_drain();
    chk("held_sum", 32'(sum), 32'h07);
    chk("done_low_after", 32'(done), 32'd0);

    do_op(8'h10, 8'h20, 1'b0, 1'b0, -1);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, -1);
    step();
    wait_drain();

    // Reset mid-operation: outputs clear at once and the aborted op never completes.
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    repeat (WIDTH + 4) step();
    chk("post_abort_idle", 32'({busy, done}), 32'd0);
    chk("post_abort_sum", 32'(sum), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, -1);
    step();
    do_op(8'h07, 8'h05, 1'b1, 1'b1, -1);
    step();
`endif

    for (int n = 0; n < 40; n++) begin
      int inj;
      logic s;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s, inj);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) step();
    end
    step();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
